// File: rtl/aes_kat_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_kat_sequencer: runs a known-answer campaign from a vector ROM through |
// | the AES-128 core and accumulates pass/fail statistics.                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module aes_kat_sequencer #(
    parameter int NUM_VECTORS = 8,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [IDX_W-1:0]   vec_addr,
    input  logic [127:0]       vec_pt,
    input  logic [127:0]       vec_key,
    input  logic [127:0]       vec_ct,
    output logic [127:0]       aes_pt,
    output logic [127:0]       aes_key,
    output logic               aes_start,
    input  logic               aes_done,
    input  logic [127:0]       aes_ct,
    output logic               busy,
    output logic               run_done,
    output logic               all_pass,
    output logic [IDX_W:0]     pass_count,
    output logic [IDX_W:0]     fail_count,
    output logic               timeout_seen,
    output logic [IDX_W-1:0]   first_fail_idx
);

    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              CW       = IDX_W + 1;
    localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [127:0]    r_exp_ct;
    logic [127:0]    r_cap_ct;
    logic            r_timed_out;
    logic            w_pass;

    // A timed-out vector fails regardless of whatever stale ct was captured.
    assign w_pass = (r_cap_ct == r_exp_ct) && !r_timed_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_exp_ct       <= '0;
            r_cap_ct       <= '0;
            r_timed_out    <= 1'b0;
            vec_addr       <= '0;
            aes_pt         <= '0;
            aes_key        <= '0;
            aes_start      <= 1'b0;
            busy           <= 1'b0;
            run_done       <= 1'b0;
            all_pass       <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            timeout_seen   <= 1'b0;
            first_fail_idx <= '0;
        end else if (busy && abort) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            aes_start <= 1'b0;
        end else begin
            aes_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        run_done <= 1'b0;
                        all_pass <= 1'b0;
                    end else if (start) begin
                        pass_count     <= '0;
                        fail_count     <= '0;
                        timeout_seen   <= 1'b0;
                        first_fail_idx <= '0;
                        run_done       <= 1'b0;
                        all_pass       <= 1'b0;
                        vec_addr       <= '0;
                        busy           <= 1'b1;
                        r_state        <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LOAD;
                S_LOAD: begin
                    aes_pt    <= vec_pt;
                    aes_key   <= vec_key;
                    r_exp_ct  <= vec_ct;
                    aes_start <= 1'b1;
                    r_state   <= S_START;
                end
                S_START: begin
                    r_timer     <= '0;
                    r_timed_out <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        r_cap_ct <= aes_ct;
                        r_state  <= S_CHECK;
                    end else if (r_timer == TMR_LAST) begin
                        r_timed_out <= 1'b1;
                        r_state     <= S_CHECK;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_pass) begin
                        pass_count <= pass_count + CW'(1);
                    end else begin
                        fail_count <= fail_count + CW'(1);
                        if (fail_count == '0) begin
                            first_fail_idx <= vec_addr;
                        end
                    end
                    timeout_seen <= timeout_seen | r_timed_out;
                    if (vec_addr == LAST_IDX) begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        run_done <= 1'b1;
                        all_pass <= (fail_count == '0) && w_pass;
                    end else begin
                        vec_addr <= vec_addr + IDX_W'(1);
                        r_state  <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
